// File: rtl/reg_file_pkg.sv
// Shared types and default widths for the multi-port register file.
package reg_file_pkg;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write port bundle of the multi-port register file.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int NR         = 3,
  parameter int NW         = 2
);

  logic [NR*ADDR_WIDTH-1:0] ra;
  logic [NR*DATA_WIDTH-1:0] rd;
  logic [NW*ADDR_WIDTH-1:0] wa;
  logic [NW*DATA_WIDTH-1:0] wd;
  logic [NW-1:0]            we;
  logic                     busy;
  logic                     wr_conflict;

  modport master (output ra, wa, wd, we, input rd, busy, wr_conflict);
  modport slave  (input ra, wa, wd, we, output rd, busy, wr_conflict);

endinterface

// File: rtl/rf_clear_ctrl.sv
// Post-reset clear sequencer: walks every entry once, then hands over to normal operation.
module rf_clear_ctrl
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  rf_state_e             state, state_nx;
  logic [ADDR_WIDTH-1:0] clr_idx;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nx;
      if (state == RF_CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  // DEPTH is a power of two, so the last index is all ones
  always_comb begin
    state_nx = state;
    if (state == RF_CLEAR && clr_idx == '1) state_nx = RF_RUN;
  end

  always_comb begin
    busy     = (state == RF_CLEAR) || !rstn;
    clr_we   = (state == RF_CLEAR) && rstn;
    clr_addr = clr_idx;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NR async reads, NW sync writes (highest port wins),
// optional write-first bypass, optional hardwired zero entry, conflict flag.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int NR         = 3,
  parameter int NW         = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic          clk,
  input  logic          rstn,
  reg_file_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]    rf [DEPTH];
  logic                     busy, clr_we;
  logic [ADDR_WIDTH-1:0]    clr_addr;
  logic [NW-1:0]            eff;
  logic                     conflict_now;
  logic                     wr_conflict;
  logic [NR*DATA_WIDTH-1:0] rd_v;

  rf_clear_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear (
    .clk      (clk),
    .rstn     (rstn),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  always_comb begin
    for (int unsigned j = 0; j < NW; j++) begin
      eff[j] = !busy && bus.we[j] &&
               !((ZERO_REG != 0) && bus.wa[j*ADDR_WIDTH +: ADDR_WIDTH] == '0);
    end
  end

  // Ascending port order: the last non-blocking write to an address wins
  always_ff @(posedge clk) begin
    if (clr_we) begin
      rf[clr_addr] <= '0;
    end else begin
      for (int unsigned j = 0; j < NW; j++) begin
        if (eff[j]) rf[bus.wa[j*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wd[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] v;
    rd_v = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      a = bus.ra[i*ADDR_WIDTH +: ADDR_WIDTH];
      v = rf[a];
      if (BYPASS != 0) begin
        for (int unsigned j = 0; j < NW; j++) begin
          if (eff[j] && bus.wa[j*ADDR_WIDTH +: ADDR_WIDTH] == a) v = bus.wd[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (busy || ((ZERO_REG != 0) && a == '0)) v = '0;
      rd_v[i*DATA_WIDTH +: DATA_WIDTH] = v;
    end
  end

  always_comb begin
    conflict_now = 1'b0;
    for (int unsigned j = 0; j < NW; j++) begin
      for (int unsigned k = j + 1; k < NW; k++) begin
        if (eff[j] && eff[k] &&
            bus.wa[j*ADDR_WIDTH +: ADDR_WIDTH] == bus.wa[k*ADDR_WIDTH +: ADDR_WIDTH])
          conflict_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) wr_conflict <= 1'b0;
    else       wr_conflict <= conflict_now;
  end

  assign bus.rd          = rd_v;
  assign bus.busy        = busy;
  assign bus.wr_conflict = wr_conflict;

endmodule
